// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: round-robin arbiter for four requesters sharing one 4:1 mux.
// Grants one owner at a time, bounded by MAX_BURST consecutive cycles, and
// drives the mux select with the owner index. All outputs are registered.
module rr_arb4_ctrl #(
    parameter int MAX_BURST = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] SEL,
    output logic       BUSY
);

    typedef enum logic {IDLE, GRANT} state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_e     state_q, state_d;
    logic [1:0] ptr_q,   ptr_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [3:0] gnt_q,   gnt_d;
    logic [1:0] sel_q,   sel_d;
    logic       busy_q,  busy_d;

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] win;
    logic       any_req;

    // Winner search: rotate REQ so PTR lands at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl = {REQ, REQ} >> ptr_q;
        req_rot = req_dbl[3:0];
        if (req_rot[0])      win_off = 2'd0;
        else if (req_rot[1]) win_off = 2'd1;
        else if (req_rot[2]) win_off = 2'd2;
        else                 win_off = 2'd3;
        win     = ptr_q + win_off;
        any_req = |REQ;
    end

    // Next-state: hold by default; load a new winner on arbitration, count while owner keeps requesting.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    cnt_d   = 4'd1;
                    ptr_d   = win + 2'd1;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                if (REQ[sel_q] && (cnt_q < MAX_CNT)) begin
                    cnt_d = cnt_q + 4'd1;
                end else if (any_req) begin
                    // Outgoing owner takes part: a sole requester wraps back to itself.
                    gnt_d  = 4'b0001 << win;
                    sel_d  = win;
                    cnt_d  = 4'd1;
                    ptr_d  = win + 2'd1;
                    busy_d = 1'b1;
                end else begin
                    // SEL keeps the last owner while idle.
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately on reset assertion.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    assign GNT  = gnt_q;
    assign SEL  = sel_q;
    assign BUSY = busy_q;

endmodule
